rf_execute_sequencer: RTL

Execute/writeback controller directly downstream of the 16-bit, 32-entry register file. Accepts one register-to-register operation at a time through a valid/ready handshake. For each operation it:
- drives the register file's two read addresses and captures the operands,
- computes the result (single-cycle ALU ops, or a 16-cycle iterative multiply),
- writes the result back through the register file's mode/write port.

---
 rtl/rf_execute_sequencer_pkg.sv | 47 ++++
 rtl/rf_execute_sequencer_mul.sv | 51 +++++
 rtl/rf_execute_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/rf_execute_sequencer_pkg.sv
// Shared widths, opcode and state encodings, and the single-cycle ALU
// used by the register-file execute sequencer.
package rf_execute_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SHL,
    OP_SHR,
    OP_MUL
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  // Returns {flag, result}; the shift amount comes from src2 bits [4:1].
  function automatic logic [DATA_W:0] alu_eval(input op_t op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W:0] r;
    logic [3:0]      amt;
    amt = b[4:1];
    r   = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_SHL:  r = {1'b0, a << amt};
      OP_SHR:  r = {1'b0, a >> amt};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rf_execute_sequencer_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, done pulses
// 16 cycles after start with the full 32-bit product.
module seq_mul_16bit
  import rf_execute_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  logic                running;
  logic [3:0]          count;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;

  // The start edge already performs iteration 0 so the product is complete
  // in time for the caller to register it on the 16th cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
        mcand   <= {{(DATA_W-1){1'b0}}, a, 1'b0};
        mplier  <= {1'b0, b[DATA_W-1:1]};
        count   <= 4'd1;
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 4'd1;
        if (count == 4'd15) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_execute_sequencer.sv
// Execute/writeback sequencer: reads two registers, runs an ALU op or an
// iterative multiply, and writes the result back to the register file.
module rf_execute_sequencer
  import rf_execute_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        InOp,
  input  logic [ADDR_W-1:0] InDest,
  input  logic [ADDR_W-1:0] InSrc1,
  input  logic [ADDR_W-1:0] InSrc2,
  output logic              RfMode,
  output logic [ADDR_W-1:0] RfWriteAddress,
  output logic [DATA_W-1:0] RfWriteValue,
  output logic [ADDR_W-1:0] RfReadAddress1,
  output logic [ADDR_W-1:0] RfReadAddress2,
  input  logic [DATA_W-1:0] RfReadValue1,
  input  logic [DATA_W-1:0] RfReadValue2,
  output logic              DoneValid,
  output logic [DATA_W-1:0] DoneResult,
  output logic              DoneCarry,
  output logic              Busy
);

  state_t              state;
  op_t                 op;
  logic [ADDR_W-1:0]   dest;
  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_product;
  logic [DATA_W:0]     alu_out;
  logic [DATA_W-1:0]   result;
  logic                carry;
  logic                exec_done;

  // The multiplier loads straight from the read ports during READ, so its
  // first iteration overlaps the operand capture edge.
  assign mul_start = (state == READ) && (op == OP_MUL);
  assign alu_out   = alu_eval(op, opa, opb);
  assign result    = (op == OP_MUL) ? mul_product[DATA_W-1:0] : alu_out[DATA_W-1:0];
  assign carry     = (op == OP_MUL) ? |mul_product[2*DATA_W-1:DATA_W] : alu_out[DATA_W];
  assign exec_done = (op != OP_MUL) || mul_done;

  seq_mul_16bit u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (RfReadValue1),
    .b       (RfReadValue2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op             <= OP_ADD;
      dest           <= '0;
      opa            <= '0;
      opb            <= '0;
      InReady        <= 1'b1;
      Busy           <= 1'b0;
      RfMode         <= 1'b0;
      RfWriteAddress <= '0;
      RfWriteValue   <= '0;
      RfReadAddress1 <= '0;
      RfReadAddress2 <= '0;
      DoneValid      <= 1'b0;
      DoneResult     <= '0;
      DoneCarry      <= 1'b0;
    end else begin
      RfMode    <= 1'b0;
      DoneValid <= 1'b0;
      unique case (state)
        IDLE: if (InValid) begin
          op             <= op_t'(InOp);
          dest           <= InDest;
          RfReadAddress1 <= InSrc1;
          RfReadAddress2 <= InSrc2;
          InReady        <= 1'b0;
          Busy           <= 1'b1;
          state          <= READ;
        end
        READ: begin
          opa   <= RfReadValue1;
          opb   <= RfReadValue2;
          state <= EXEC;
        end
        EXEC: if (exec_done) begin
          RfMode         <= 1'b1;
          RfWriteAddress <= dest;
          RfWriteValue   <= result;
          DoneValid      <= 1'b1;
          DoneResult     <= result;
          DoneCarry      <= carry;
          state          <= WRITE;
        end
        WRITE: begin
          InReady <= 1'b1;
          Busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
